// File: rtl/conv_tile_serializer.sv
// Two-entry ping-pong tile buffer that drains convolution output tiles as a float16 element stream.
// Optional SERIALIZER_RELU_EN: zero negative elements at the output mux.
module conv_tile_serializer #(
    parameter int PARA_X     = 3,
    parameter int PARA_Y     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4,
    localparam int TILE_N    = PARA_X * PARA_Y
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tile_valid,
    input  logic [TILE_N*DATA_WIDTH-1:0] tile_data,
    output logic                         tile_full,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [IDX_WIDTH-1:0]         out_index,
    output logic                         out_last,
    output logic [15:0]                  tile_count,
    output logic                         overflow
);

    typedef logic [TILE_N-1:0][DATA_WIDTH-1:0] tile_t;

    tile_t                 entry0_q, entry1_q, entry0_d, entry1_d, tileIn, selTile;
    logic                  wp_q, wp_d, rp_q, rp_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  outValid_q, outValid_d, outLast_q, outLast_d;
    logic                  tileFull_q, tileFull_d, overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d, elem;
    logic [15:0]           tileCount_q, tileCount_d;
    logic                  fire, popLast, capture;

    assign tileIn  = tileIn_t(tile_data);
    assign fire    = outValid_q & out_ready;
    assign popLast = fire & (idx_q == IDX_WIDTH'(TILE_N - 1));
    assign capture = tile_valid & ((cnt_q != 2'd2) | popLast);

    function automatic tile_t tileIn_t(input logic [TILE_N*DATA_WIDTH-1:0] v);
        return tile_t'(v);
    endfunction

    // Outputs are computed from next-state so each element appears right after its pointer update.
    always_comb begin
        entry0_d    = entry0_q;
        entry1_d    = entry1_q;
        wp_d        = wp_q ^ capture;
        rp_d        = rp_q ^ popLast;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tileCount_d = tileCount_q;
        overflow_d  = overflow_q | (tile_valid & ~capture);
        if (capture) begin
            if (wp_q) entry1_d = tileIn;
            else      entry0_d = tileIn;
        end
        if (capture && !popLast)      cnt_d = cnt_q + 2'd1;
        else if (!capture && popLast) cnt_d = cnt_q - 2'd1;
        if (popLast) begin
            idx_d       = '0;
            tileCount_d = tileCount_q + 16'd1;
        end else if (fire) begin
            idx_d = idx_q + IDX_WIDTH'(1);
        end
        selTile    = rp_d ? entry1_d : entry0_d;
        elem       = selTile[idx_d];
        outValid_d = (cnt_d != 2'd0);
        outLast_d  = outValid_d & (idx_d == IDX_WIDTH'(TILE_N - 1));
        tileFull_d = (cnt_d == 2'd2);
`ifdef SERIALIZER_RELU_EN
        outData_d  = elem[DATA_WIDTH-1] ? '0 : elem;
`else
        outData_d  = elem;
`endif
    end

    always_ff @(posedge clk) begin
        entry0_q <= entry0_d;
        entry1_q <= entry1_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            cnt_q       <= 2'd0;
            idx_q       <= '0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            outData_q   <= '0;
            tileFull_q  <= 1'b0;
            tileCount_q <= 16'd0;
            overflow_q  <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            outValid_q  <= outValid_d;
            outLast_q   <= outLast_d;
            outData_q   <= outData_d;
            tileFull_q  <= tileFull_d;
            tileCount_q <= tileCount_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid  = outValid_q;
    assign out_index  = idx_q;
    assign out_last   = outLast_q;
    assign out_data   = outData_q;
    assign tile_full  = tileFull_q;
    assign tile_count = tileCount_q;
    assign overflow   = overflow_q;

endmodule
